// File: rtl/rx_bit_timer.sv
// rx_bit_timer: serial receive front end. Detects a start bit on a synchronized,
// idle-high line, samples each bit at its centre, shifts DATA_BITS bits in
// LSB-first, checks the stop bit and presents the word over valid/ready.
//
// Ports:
//   clk            system clock, rising edge
//   rst            asynchronous active-high reset
//   serial_in      synchronized serial line (idles high)
//   rx_ready       downstream accepts rx_data at this edge
//   rx_valid       rx_data holds an unconsumed word
//   rx_data        last received word, bit 0 = first bit on the line
//   framing_error  stop bit of the word in rx_data was 0
//   overrun_error  a completed word was dropped while rx_valid was pending
//   busy           receiver is not idle (registered)
//   sample_strobe  one-cycle pulse following each data-bit sample
module rx_bit_timer #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 serial_in,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 busy,
  output logic                 sample_strobe
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);
  localparam int unsigned HALF  = CLKS_PER_BIT / 2;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 prev_q;
  logic                 armed_q;
  logic                 strobe_d;
  logic                 stop_sample;
  logic                 load;
  logic                 xfer;
  logic                 valid_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 fe_d;
  logic                 ov_d;

  // Next-state, counters, shift register and handshake outputs
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    strobe_d    = 1'b0;
    stop_sample = 1'b0;

    case (state_q)
      IDLE: begin
        // armed_q blocks a false start when the line is low coming out of reset
        if (armed_q && prev_q && !serial_in) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == CNT_W'(HALF - 1)) begin
          cnt_d = '0;
          if (!serial_in) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d                = '0;
          shift_d              = shift_q >> 1;
          shift_d[DATA_BITS-1] = serial_in;
          strobe_d             = 1'b1;
          idx_d                = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(DATA_BITS - 1)) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          cnt_d       = '0;
          stop_sample = 1'b1;
          state_d     = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    xfer    = rx_valid && rx_ready;
    load    = stop_sample && (!rx_valid || rx_ready);
    valid_d = rx_valid;
    data_d  = rx_data;
    fe_d    = framing_error;
    ov_d    = overrun_error;

    if (load) begin
      valid_d = 1'b1;
      data_d  = shift_q;
      fe_d    = !serial_in;
    end else if (xfer) begin
      valid_d = 1'b0;
    end

    if (xfer) begin
      ov_d = 1'b0;
    end else if (stop_sample && rx_valid) begin
      ov_d = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      prev_q        <= 1'b1;
      armed_q       <= 1'b0;
      rx_valid      <= 1'b0;
      rx_data       <= '0;
      framing_error <= 1'b0;
      overrun_error <= 1'b0;
      busy          <= 1'b0;
      sample_strobe <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      prev_q        <= serial_in;
      armed_q       <= armed_q | serial_in;
      rx_valid      <= valid_d;
      rx_data       <= data_d;
      framing_error <= fe_d;
      overrun_error <= ov_d;
      busy          <= (state_q != IDLE);
      sample_strobe <= strobe_d;
    end
  end

endmodule

// File: tb/tb_rx_bit_timer.sv
// tb_rx_bit_timer: table-driven frames plus hand-written corner sequences;
// expected words queue up when driven and are compared when transferred.
module tb_rx_bit_timer;

  localparam int unsigned DB   = 8;
  localparam int unsigned C    = 10;
  localparam int unsigned HALF = C / 2;

  logic          tb_clk = 1'b0;
  logic          rst;
  logic          serial_in;
  logic          rx_ready;
  logic          rx_valid;
  logic [DB-1:0] rx_data;
  logic          framing_error;
  logic          overrun_error;
  logic          busy;
  logic          sample_strobe;

  rx_bit_timer #(.DATA_BITS(DB), .CLKS_PER_BIT(C)) dut (
    .clk           (tb_clk),
    .rst           (rst),
    .serial_in     (serial_in),
    .rx_ready      (rx_ready),
    .rx_valid      (rx_valid),
    .rx_data       (rx_data),
    .framing_error (framing_error),
    .overrun_error (overrun_error),
    .busy          (busy),
    .sample_strobe (sample_strobe)
  );

  always #5 tb_clk = ~tb_clk;

  typedef struct packed {
    logic [DB-1:0] d;
    logic          fe;
  } exp_t;

  typedef struct packed {
    logic [DB-1:0] d;
    logic          stop;
    logic [DB-1:0] exp_d;
    logic          exp_fe;
  } vec_t;

  exp_t exp_q[$];
  exp_t sb_e;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int e_cyc = 0;
  int strobe_total = 0;
  int strobe_base = 0;
  int valid_rise_cyc = -1;
  int busy_rise_cyc = -1;
  int busy_fall_cyc = -1;
  logic valid_prev = 1'b0;
  logic busy_prev = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge tb_clk) cyc <= cyc + 1;

  // Monitor: edge timestamps, strobe timing, scoreboard pop on transfer
  always @(negedge tb_clk) begin
    if (!rst) begin
      if (rx_valid && !valid_prev) valid_rise_cyc = cyc;
      if (busy && !busy_prev) busy_rise_cyc = cyc;
      if (!busy && busy_prev) busy_fall_cyc = cyc;
      if (sample_strobe) begin
        chk("strobe_time", 32'(cyc),
            32'(e_cyc + int'(HALF) + (strobe_total - strobe_base + 1) * int'(C)));
        strobe_total++;
      end
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_word", 32'(rx_data), 32'hFFFF_FFFF);
        end else begin
          sb_e = exp_q.pop_front();
          chk("sb_data", 32'(rx_data), 32'(sb_e.d));
          chk("sb_fe", 32'(framing_error), 32'(sb_e.fe));
        end
      end
    end
    valid_prev = rx_valid;
    busy_prev  = busy;
  end

  task automatic tick();
    @(posedge tb_clk);
    #1;
  endtask

  // Drive one frame; the start bit is first seen at edge e_cyc
  task automatic send_frame(input logic [DB-1:0] d, input logic stop,
                            input logic push, input logic ready_at_stop);
    serial_in   = 1'b0;
    e_cyc       = cyc + 1;
    strobe_base = strobe_total;
    repeat (C) tick();
    for (int k = 0; k < int'(DB); k++) begin
      serial_in = d[k];
      repeat (C) tick();
    end
    serial_in = stop;
    if (push) exp_q.push_back('{d: d, fe: !stop});
    if (ready_at_stop) begin
      repeat (HALF) tick();
      rx_ready = 1'b1;
      tick();
      rx_ready = 1'b0;
      repeat (C - HALF - 1) tick();
    end else begin
      repeat (C) tick();
    end
    serial_in = 1'b1;
  endtask

  task automatic consume();
    rx_ready = 1'b1;
    tick();
    rx_ready = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, 32'(rx_valid), 32'd0);
    chk({tag, "_data"},  32'(rx_data), 32'd0);
    chk({tag, "_fe"},    32'(framing_error), 32'd0);
    chk({tag, "_ov"},    32'(overrun_error), 32'd0);
    chk({tag, "_busy"},  32'(busy), 32'd0);
    chk({tag, "_strobe"}, 32'(sample_strobe), 32'd0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{d: 8'hA5, stop: 1'b1, exp_d: 8'hA5, exp_fe: 1'b0};
    vecs[1] = '{d: 8'h3C, stop: 1'b0, exp_d: 8'h3C, exp_fe: 1'b1};
    vecs[2] = '{d: 8'h00, stop: 1'b1, exp_d: 8'h00, exp_fe: 1'b0};
    vecs[3] = '{d: 8'hFF, stop: 1'b1, exp_d: 8'hFF, exp_fe: 1'b0};
    vecs[4] = '{d: 8'h81, stop: 1'b0, exp_d: 8'h81, exp_fe: 1'b1};

    rst       = 1'b1;
    serial_in = 1'b1;
    rx_ready  = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");

    // Line held low while leaving reset: no start until it rises and falls
    serial_in = 1'b0;
    tick();
    rst = 1'b0;
    repeat (20) tick();
    chk("low_at_reset_busy", 32'(busy), 32'd0);
    serial_in = 1'b1;
    repeat (5) tick();
    chk("low_at_reset_busy2", 32'(busy), 32'd0);
    chk("low_at_reset_strobes", 32'(strobe_total), 32'd0);

    // Table-driven frames, each held pending then consumed
    for (int i = 0; i < 5; i++) begin
      send_frame(vecs[i].d, vecs[i].stop, 1'b1, 1'b0);
      chk("valid_rise_time", 32'(valid_rise_cyc), 32'(e_cyc + 95));
      chk("busy_rise_time",  32'(busy_rise_cyc),  32'(e_cyc + 1));
      chk("busy_fall_time",  32'(busy_fall_cyc),  32'(e_cyc + 96));
      chk("strobe_count",    32'(strobe_total - strobe_base), 32'(DB));
      chk("vec_valid", 32'(rx_valid), 32'd1);
      chk("vec_data",  32'(rx_data), 32'(vecs[i].exp_d));
      chk("vec_fe",    32'(framing_error), 32'(vecs[i].exp_fe));
      chk("vec_ov",    32'(overrun_error), 32'd0);
      consume();
      chk("vec_valid_cleared", 32'(rx_valid), 32'd0);
      repeat (5) tick();
    end

    // Glitch: start bit only 3 cycles long
    serial_in   = 1'b0;
    e_cyc       = cyc + 1;
    strobe_base = strobe_total;
    repeat (3) tick();
    serial_in = 1'b1;
    repeat (20) tick();
    chk("glitch_busy_fall", 32'(busy_fall_cyc), 32'(e_cyc + 6));
    chk("glitch_valid", 32'(rx_valid), 32'd0);
    chk("glitch_strobes", 32'(strobe_total - strobe_base), 32'd0);

    // Overrun: second frame dropped while first still pending
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0, 1'b0);
    chk("ovr_data",  32'(rx_data), 32'h11);
    chk("ovr_valid", 32'(rx_valid), 32'd1);
    chk("ovr_flag",  32'(overrun_error), 32'd1);
    consume();
    chk("ovr_valid_cleared", 32'(rx_valid), 32'd0);
    chk("ovr_flag_cleared",  32'(overrun_error), 32'd0);
    repeat (5) tick();

    // Simultaneous load and accept at the stop-sample edge
    send_frame(8'h11, 1'b1, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b1, 1'b1);
    chk("simul_data",  32'(rx_data), 32'h22);
    chk("simul_valid", 32'(rx_valid), 32'd1);
    chk("simul_ov",    32'(overrun_error), 32'd0);
    chk("simul_fe",    32'(framing_error), 32'd0);

    // Reset mid-frame with 0x22 still pending
    serial_in   = 1'b0;
    e_cyc       = cyc + 1;
    strobe_base = strobe_total;
    repeat (C) tick();
    for (int k = 0; k < 3; k++) begin
      serial_in = k[0] ? 1'b0 : 1'b1;
      repeat (C) tick();
    end
    serial_in = 1'b0;
    tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_all_zero("midreset");
    exp_q.delete();
    tick();
    rst       = 1'b0;
    serial_in = 1'b1;
    repeat (C) tick();
    chk("post_reset_idle", 32'(busy), 32'd0);
    send_frame(8'h5A, 1'b1, 1'b1, 1'b0);
    chk("after_reset_valid_time", 32'(valid_rise_cyc), 32'(e_cyc + 95));
    chk("after_reset_data", 32'(rx_data), 32'h5A);
    chk("after_reset_fe",   32'(framing_error), 32'd0);
    consume();
    repeat (5) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rx_bit_timer.md
# rx_bit_timer

Serial receive front end for the project datapath. It detects a start bit on an already-synchronized, idle-high serial line and times each bit to its centre. It shifts in DATA_BITS data bits LSB-first, checks the stop bit, and presents each completed word through a valid/ready handshake. It sits directly upstream of the flex_counter-based packet/byte counting stage, which consumes `rx_valid` as its `count_enable`.

## Interface
- `DATA_BITS`, default 8: data bits per frame (1..16).
- `CLKS_PER_BIT`, default 10: clock cycles per serial bit; must be even and ≥4.
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `serial_in` in 1: serial line, already synchronized to `clk`; idles high.
- `rx_ready` in 1: downstream accepts `rx_data` at the current edge.
- `rx_valid` out 1: `rx_data` holds an unconsumed word.
- `rx_data` out DATA_BITS: last received word; bit 0 is the first bit on the line.
- `framing_error` out 1: stop bit of the word in `rx_data` was 0.
- `overrun_error` out 1: a completed word was dropped because `rx_valid` was still pending.
- `busy` out 1: the FSM is not in IDLE.
- `sample_strobe` out 1: one-cycle pulse following each data-bit sample.

## Operation
- **Reset values.** Asserting `rst` forces these immediately, regardless of `clk`:
  - state IDLE, bit-period counter 0, bit index 0;
  - `prev_serial` 1, shift register 0;
  - all outputs 0.
- **IDLE.** A falling edge is `serial_in`=0 while `prev_serial`=1. On that edge:
  - go to START;
  - clear the counter.
- **START.** Wait half a bit, then sample `serial_in`:
  - 0: go to DATA and clear the counter and bit index;
  - 1: glitch; return to IDLE with no output change.
- **DATA.** The counter runs 0..CLKS_PER_BIT-1 and wraps to 0.
  - At the terminal count, sample `serial_in` into the shift register: shift right, new bit enters the MSB. After DATA_BITS samples, bit 0 is the first bit received.
  - Pulse `sample_strobe` in the following cycle.
  - Increment the bit index. After the DATA_BITS-th sample, go to STOP.
- **STOP.** Count one full bit period, then sample the stop bit.
  - If `rx_valid`=0, or `rx_valid`=1 with `rx_ready`=1 at the same edge:
    - load `rx_data` from the shift register;
    - `framing_error` ← NOT stop bit;
    - `rx_valid` ← 1.
  - Otherwise (`rx_valid`=1, `rx_ready`=0):
    - keep `rx_data` and `framing_error`;
    - `overrun_error` ← 1.
  - In every case, return to IDLE.
- **Handshake.**
  - Transfer occurs at any edge with `rx_valid`=1 and `rx_ready`=1.
  - On a transfer with no simultaneous load, `rx_valid` ← 0.
  - `overrun_error` clears on any transfer.
  - `rx_data` and `framing_error` hold their values until the next load.
- **Widths.**
  - Counter is clog2(CLKS_PER_BIT) bits; bit index is clog2(DATA_BITS+1) bits.
  - No arithmetic overflow is permitted: every counter wraps explicitly.
- **`busy`** = state ≠ IDLE, registered.

## Timing
- **Reference edge.** E is the rising edge at which the falling edge is detected (`serial_in` first seen 0).
- **Start sample:** edge E + CLKS_PER_BIT/2.
- **Data bit k** (k = 0..DATA_BITS-1): sampled at edge E + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT; `sample_strobe` is high in the cycle after that edge.
- **Stop sample:** edge E + CLKS_PER_BIT/2 + (DATA_BITS+1)·CLKS_PER_BIT.
  - `rx_valid`, `rx_data` and `framing_error` update at this edge.
  - Defaults: start E+5, data E+15…E+85, stop E+95.
- **`busy`:** high from the edge after E through the stop-sample edge; low after it.
  - A new falling edge can be detected from the edge after the stop sample.
  - Back-to-back frames are supported.
- **Line changes.** `serial_in` changes between sample edges are ignored. Only the sampled values matter.
- **Reset mid-frame.** The partial frame is discarded; no `rx_valid` results.
- **Start while line low.** If `serial_in` is 0 when leaving reset, no start is detected until the line has returned high and fallen again.

## Test plan
- **Good frame, defaults.** Send 0xA5 (line 0,1,0,1,0,0,1,0,1, then stop 1) with `rx_ready`=0 → at E+95 `rx_valid`=1, `rx_data`=0xA5, `framing_error`=0; exactly 8 `sample_strobe` pulses.
- **Glitch.** `serial_in` low for 3 cycles, then high → `busy` drops after E+5; `rx_valid` stays 0; no strobes.
- **Bad stop bit.** Send 0x3C with stop bit 0 → `rx_data`=0x3C, `framing_error`=1, `rx_valid`=1.
- **Overrun.**
  - Send 0x11 then 0x22 back-to-back with `rx_ready`=0 → `rx_data`=0x11, `overrun_error`=1.
  - Then pulse `rx_ready` for one cycle → `rx_valid`=0 and `overrun_error`=0 on the next cycle.
- **Simultaneous load and accept.** `rx_valid`=1 (0x11); assert `rx_ready` exactly at the stop-sample edge of 0x22 → `rx_data`=0x22, `rx_valid` stays 1, `overrun_error`=0.
- **Reset mid-frame.** Assert `rst` at E+40 for one cycle → all outputs 0 immediately. A following 0x5A frame is received correctly with `framing_error`=0.
